data_memory_banked: RTL and testbench
=====================================

DATA_MEMORY_BANKED -- requirements
Module: data_memory_banked

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, meaning the bank count (power of two, 1..16).
REQ-002 SHALL have parameter BANK_DEPTH, default 4096, meaning 32-bit words per bank (power of two).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port mem_read, input, 1 bit: load request this cycle.
REQ-006 SHALL have port mem_write, input, 1 bit: store request this cycle.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port write_data, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-010 SHALL have port load_unsigned, input, 1 bit: zero-extend sub-word loads when 1, sign-extend when 0.
REQ-011 SHALL have port read_data, output, 32 bits: aligned, extended load result.
REQ-012 SHALL have port read_valid, output, 1 bit: read_data valid this cycle.
REQ-013 SHALL have port misalign_err, output, 1 bit: one-cycle pulse for a misaligned request.
REQ-014 SHALL have port range_err, output, 1 bit: one-cycle pulse for an out-of-range request.

Function
REQ-015 SHALL decode word index = addr[IW+1:2] (IW = log2 BANK_DEPTH) and bank = the next log2 NUM_BANKS bits.
REQ-016 SHALL enable only the selected bank; all other banks stay idle.
REQ-017 SHALL flag a range error when any addr bit above the bank field is 1; no bank is accessed.
REQ-018 SHALL flag a misalignment when half has addr[0]=1, or word has addr[1:0]!=0; no bank is accessed.
REQ-019 SHALL write byte lanes as follows: byte -> lane addr[1:0], data byte replicated to all lanes; half -> lanes {1,0} or {3,2}, data half replicated; word -> all lanes.
REQ-020 SHALL give load latency 1: a request at edge N yields read_valid=1 and read_data in the cycle after edge N.
REQ-021 SHALL register bank select, addr[1:0], size and load_unsigned at the request edge, then use the registered copies for output mux and extraction.
REQ-022 SHALL extract byte/half at the registered offset and sign- or zero-extend it to 32 bits.
REQ-023 SHALL drive read_data = 0 whenever read_valid = 0.
REQ-024 SHALL give priority to the write when mem_read and mem_write are both 1: store performed, read_valid stays 0.
REQ-025 SHALL drive misalign_err/range_err one cycle after the request, with read_valid = 0; range_err takes precedence over misalign_err.
REQ-026 SHALL sustain back-to-back loads, one per cycle, across different banks without bubbles.
REQ-027 SHALL return the newly written data for a load issued the cycle after a store to the same word.

Reset
REQ-028 SHALL clear read_valid, misalign_err, range_err, read_data and all pipeline registers immediately when rst_n = 0.
REQ-029 SHALL gate all bank enables with rst_n, so no write occurs while in reset.
REQ-030 SHALL NOT clear memory contents on reset.
REQ-031 SHALL discard a load in flight when reset asserts; no read_valid is raised after release.

Structure
REQ-032 SHALL place size encodings, default parameter values and the byte-lane enable function in package data_mem_pkg.
REQ-033 SHALL implement each bank as sub-module dmem_bank: synchronous 1RW, BANK_DEPTH x 32, per-byte write enables, registered Q.

Verification
REQ-034 SHALL check: sw 0xDEADBEEF @0x0000_0008, then lw @0x0000_0008 -> read_valid one cycle later, read_data 0xDEADBEEF.
REQ-035 SHALL check: sb 0x80 @0x0000_4001 (bank 1), then lb -> 0xFFFFFF80 and lbu -> 0x00000080; bank 0 word 0 is unchanged.
REQ-036 SHALL check: sh @0x0000_0003 -> misalign_err pulse for 1 cycle; a later lw @0x0000_0000 returns the prior value.
REQ-037 SHALL check: lw @0x0001_0000 (defaults) -> range_err=1, read_valid=0, read_data=0.
REQ-038 SHALL check: 4 consecutive lw, one per bank (0x0, 0x4000, 0x8000, 0xC000) -> 4 consecutive valid cycles with the correct data each.
REQ-039 SHALL check: rst_n low in the cycle after a lw request -> read_valid stays 0; a sw asserted during reset leaves memory unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings, default geometry and byte-lane decode for the banked data memory.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } size_e;

  localparam int unsigned DefNumBanks  = 4;
  localparam int unsigned DefBankDepth = 4096;

  // Reserved size behaves as a full word.
  function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] lanes;
    unique case (size_e'(size))
      SizeByte: lanes = 4'b0001 << off;
      SizeHalf: lanes = off[1] ? 4'b1100 : 4'b0011;
      default:  lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One memory bank: synchronous single-port RAM with per-byte write enables and registered read.
module dmem_bank #(
  parameter int unsigned BANK_DEPTH = 4096,
  localparam int unsigned AW = $clog2(BANK_DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [BANK_DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int b = 0; b < 4; b++) begin
          if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory_banked.sv
// Banked byte-addressable data memory with 1-cycle loads, sub-word access and error pulses.
module data_memory_banked
  import data_mem_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = DefNumBanks,
  parameter int unsigned BANK_DEPTH = DefBankDepth
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        misalign_err,
  output logic        range_err
);

  localparam int unsigned IW     = $clog2(BANK_DEPTH);
  localparam int unsigned BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int unsigned SelW   = (BW > 0) ? BW : 1;
  localparam int unsigned TopBit = IW + 2 + BW;

  logic [IW-1:0]   word_idx;
  logic [SelW-1:0] bank_sel;
  logic            req, range_hit, misaligned, access_ok;
  logic [3:0]      lanes;
  logic [31:0]     wdata_rep;
  logic [31:0]     bank_rdata [NUM_BANKS];

  logic            valid_q, mis_q, rng_q, uns_q;
  logic [SelW-1:0] bank_q;
  logic [1:0]      off_q, size_q;

  assign word_idx = addr[IW+1:2];

  if (BW > 0) begin : g_sel
    assign bank_sel = addr[IW+2 +: SelW];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  assign req       = mem_read | mem_write;
  assign range_hit = |(addr & (32'hFFFF_FFFF << TopBit));
  assign lanes     = byte_lanes(size, addr[1:0]);

  always_comb begin
    misaligned = 1'b0;
    wdata_rep  = write_data;
    unique case (size_e'(size))
      SizeByte: wdata_rep = {4{write_data[7:0]}};
      SizeHalf: begin
        misaligned = addr[0];
        wdata_rep  = {2{write_data[15:0]}};
      end
      default:  misaligned = |addr[1:0];
    endcase
  end

  assign access_ok = req & ~range_hit & ~misaligned;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic bank_en;
    // rst_n in the enable keeps stores issued during reset from landing.
    assign bank_en = rst_n & access_ok & (bank_sel == SelW'(i));

    dmem_bank #(
      .BANK_DEPTH(BANK_DEPTH)
    ) u_bank (
      .clk  (clk),
      .en   (bank_en),
      .we   (mem_write ? lanes : 4'b0000),
      .addr (word_idx),
      .wdata(wdata_rep),
      .rdata(bank_rdata[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
      uns_q   <= 1'b0;
      bank_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
    end else begin
      valid_q <= mem_read & ~mem_write & access_ok;
      mis_q   <= req & ~range_hit & misaligned;
      rng_q   <= req & range_hit;
      uns_q   <= load_unsigned;
      bank_q  <= bank_sel;
      off_q   <= addr[1:0];
      size_q  <= size;
    end
  end

  logic [31:0] word, shifted, ext;

  always_comb begin
    word    = bank_rdata[bank_q];
    shifted = word >> {off_q, 3'b000};
    unique case (size_e'(size_q))
      SizeByte: ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SizeHalf: ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:  ext = word;
    endcase
  end

  assign read_data    = valid_q ? ext : 32'h0;
  assign read_valid   = valid_q;
  assign misalign_err = mis_q;
  assign range_err    = rng_q;

endmodule

// File: tb/tb_data_memory_banked.sv
// Self-checking bench for data_memory_banked against a byte-array memory model.
module tb_data_memory_banked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [31:0] addr = '0, write_data = '0;
  logic [1:0]  size = 2'b00;
  logic [31:0] read_data;
  logic        read_valid, misalign_err, range_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_b [int unsigned];

  always #5 clk = ~clk;

  data_memory_banked dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .write_data   (write_data),
    .size         (size),
    .load_unsigned(load_unsigned),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .misalign_err (misalign_err),
    .range_err    (range_err)
  );

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Default geometry: 4 banks x 4096 words = 64 KiB addressable.
  function automatic logic ref_range(input logic [31:0] a);
    return a >= 32'h0001_0000;
  endfunction

  function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
    return !ref_range(a) && ((a % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    for (int i = 0; i < nbytes(sz); i++) mem_b[a + i] = wd[8*i +: 8];
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    mem_read = rd; mem_write = wr; addr = a; write_data = wd; size = sz; load_unsigned = uns;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (read_valid !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_read: valid=%b data=%h, want 0/0", read_valid, read_data);
    end
    checks++;
    if (misalign_err !== 1'b0 || range_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: mis=%b rng=%b, want 0/0", misalign_err, range_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw();
    issue(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 2'b10, 1'b0);
    ref_store(32'h8, 32'hDEAD_BEEF, 2'b10);
    checks++;
    if (read_valid !== 1'b0) begin
      failures++;
      $display("FAIL sw_no_valid: valid=%b, want 0", read_valid);
    end
    issue(1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
    checks++;
    if (read_valid !== 1'b1 || read_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lw_word: valid=%b data=%h, want 1/deadbeef", read_valid, read_data);
    end
  endtask

  task automatic test_byte();
    issue(1'b0, 1'b1, 32'h0, 32'h1122_3344, 2'b10, 1'b0);
    ref_store(32'h0, 32'h1122_3344, 2'b10);
    issue(1'b0, 1'b1, 32'h4000, 32'hA5A5_A5A5, 2'b10, 1'b0);
    ref_store(32'h4000, 32'hA5A5_A5A5, 2'b10);
    issue(1'b0, 1'b1, 32'h4001, 32'h0000_0080, 2'b00, 1'b0);
    ref_store(32'h4001, 32'h80, 2'b00);
    issue(1'b1, 1'b0, 32'h4001, 32'h0, 2'b00, 1'b0);
    checks++;
    if (read_valid !== 1'b1 || read_data !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL lb_sign: valid=%b data=%h, want 1/ffffff80", read_valid, read_data);
    end
    issue(1'b1, 1'b0, 32'h4001, 32'h0, 2'b00, 1'b1);
    checks++;
    if (read_valid !== 1'b1 || read_data !== 32'h0000_0080) begin
      failures++;
      $display("FAIL lbu_zero: valid=%b data=%h, want 1/00000080", read_valid, read_data);
    end
    issue(1'b1, 1'b0, 32'h4000, 32'h0, 2'b10, 1'b0);
    checks++;
    if (read_data !== 32'hA5A5_80A5) begin
      failures++;
      $display("FAIL sb_lane: data=%h, want a5a580a5", read_data);
    end
    issue(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    checks++;
    if (read_data !== 32'h1122_3344) begin
      failures++;
      $display("FAIL bank0_untouched: data=%h, want 11223344", read_data);
    end
  endtask

  task automatic test_misalign();
    issue(1'b0, 1'b1, 32'h3, 32'h0000_BEEF, 2'b01, 1'b0);
    checks++;
    if (misalign_err !== 1'b1 || range_err !== 1'b0 || read_valid !== 1'b0) begin
      failures++;
      $display("FAIL sh_misalign: mis=%b rng=%b valid=%b, want 1/0/0",
               misalign_err, range_err, read_valid);
    end
    idle();
    checks++;
    if (misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse: mis=%b, want 0", misalign_err);
    end
    issue(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    checks++;
    if (read_valid !== 1'b1 || read_data !== 32'h1122_3344) begin
      failures++;
      $display("FAIL misalign_nowrite: valid=%b data=%h, want 1/11223344", read_valid, read_data);
    end
  endtask

  task automatic test_range();
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0, 2'b10, 1'b0);
    checks++;
    if (range_err !== 1'b1 || misalign_err !== 1'b0 || read_valid !== 1'b0 ||
        read_data !== 32'h0) begin
      failures++;
      $display("FAIL lw_range: rng=%b mis=%b valid=%b data=%h, want 1/0/0/0",
               range_err, misalign_err, read_valid, read_data);
    end
    idle();
    checks++;
    if (range_err !== 1'b0) begin
      failures++;
      $display("FAIL range_pulse: rng=%b, want 0", range_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    for (int b = 0; b < 4; b++) begin
      vals[b] = $urandom;
      issue(1'b0, 1'b1, 32'(b) << 14, vals[b], 2'b10, 1'b0);
      ref_store(32'(b) << 14, vals[b], 2'b10);
    end
    for (int b = 0; b < 4; b++) begin
      issue(1'b1, 1'b0, 32'(b) << 14, 32'h0, 2'b10, 1'b0);
      checks++;
      if (read_valid !== 1'b1 || read_data !== vals[b]) begin
        failures++;
        $display("FAIL b2b_bank%0d: valid=%b data=%h, want 1/%h", b, read_valid, read_data,
                 vals[b]);
      end
    end
    idle();
    checks++;
    if (read_valid !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL b2b_tail: valid=%b data=%h, want 0/0", read_valid, read_data);
    end
  endtask

  task automatic test_reset_inflight();
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h8; size = 2'b10; load_unsigned = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (read_valid !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_flush: valid=%b data=%h, want 0/0", read_valid, read_data);
    end
    issue(1'b0, 1'b1, 32'h8, 32'h0BAD_F00D, 2'b10, 1'b0);
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checks++;
    if (read_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_valid: valid=%b, want 0", read_valid);
    end
    issue(1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
    checks++;
    if (read_data !== ref_load(32'h8, 2'b10, 1'b0)) begin
      failures++;
      $display("FAIL reset_no_write: data=%h, want %h", read_data, ref_load(32'h8, 2'b10, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] a, wd, exp_data;
    logic [1:0]  sz;
    logic        rd, wr, uns, e_rng, e_mis, e_valid;
    int          op;
    for (int i = 0; i < 8; i++) begin
      pool[i] = (32'(i % 4) << 14) | (32'($urandom_range(16, 4095)) << 2);
      wd = $urandom;
      issue(1'b0, 1'b1, pool[i], wd, 2'b10, 1'b0);
      ref_store(pool[i], wd, 2'b10);
    end
    for (int n = 0; n < 300; n++) begin
      a   = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'h0001_0000 << $urandom_range(0, 15));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      op  = $urandom_range(0, 3);
      rd  = (op == 1 || op == 2 || op == 3);
      wr  = (op == 0 || op == 3);
      e_rng    = ref_range(a);
      e_mis    = ref_mis(a, sz);
      e_valid  = rd && !wr && !e_rng && !e_mis;
      exp_data = e_valid ? ref_load(a, sz, uns) : 32'h0;
      issue(rd, wr, a, wd, sz, uns);
      if (wr && !e_rng && !e_mis) ref_store(a, wd, sz);
      checks++;
      if (read_valid !== e_valid || read_data !== exp_data || range_err !== e_rng ||
          misalign_err !== e_mis) begin
        failures++;
        $display("FAIL rand%0d a=%h sz=%0d rd=%b wr=%b: valid=%b data=%h rng=%b mis=%b, want %b/%h/%b/%b",
                 n, a, sz, rd, wr, read_valid, read_data, range_err, misalign_err,
                 e_valid, exp_data, e_rng, e_mis);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte();
    test_misalign();
    test_range();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
